wbck_unit: RTL and testbench

Writeback unit driving both write ports of the core register file. Registers ALU/EX results onto the `wbck_*` port and queues load responses from the LSU in a small FIFO, draining them onto the `Men_wb`/`Mrd_wb`/`Mdata_wb` port with sub-word extraction. Sits between the EX/LSU stages and the register file. Clears scoreboard flags implicitly, because every accepted instruction with a non-zero `rd` produces exactly one register-file write.

---
 rtl/wbck_unit.sv | 149 ++++++++++++++
 tb/tb_wbck_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbck_unit.sv
// rtl/wbck_unit.sv - register-file writeback: registered EX port plus load-response FIFO port
// Define WBCK_LOAD_EXT_EN to enable funct3/addr_lo sub-word load extraction at push time.
module wbck_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_regwrite,
  input  logic [IDX_W-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             lsu_rsp_valid,
  output logic             lsu_rsp_ready,
  input  logic [IDX_W-1:0] lsu_rsp_rd,
  input  logic [XLEN-1:0]  lsu_rsp_data,
  input  logic [2:0]       lsu_rsp_funct3,
  input  logic [1:0]       lsu_rsp_addr_lo,
  input  logic             lsu_rsp_err,
  input  logic             wb_hold,
  output logic             wbck_en,
  output logic [IDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]  wbck_dest_data,
  output logic             Men_wb,
  output logic [IDX_W-1:0] Mrd_wb,
  output logic [XLEN-1:0]  Mdata_wb,
  output logic             load_pending,
  output logic             load_err
);
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);

  logic             r_wbck_en;
  logic [IDX_W-1:0] r_wbck_idx;
  logic [XLEN-1:0]  r_wbck_data;

  logic [IDX_W-1:0]    r_rd_mem   [LQ_DEPTH];
  logic [XLEN-1:0]     r_data_mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] r_err_mem;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_ex_write;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_ext_data;
  logic            w_ext_err;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  assign ex_ready      = ~rst & ~wb_hold;
  assign lsu_rsp_ready = ~rst & ~w_full;

  assign w_ex_write = ex_valid & ex_ready & ex_regwrite & (ex_rd != '0);
  // rd==0 responses are consumed but never stored: x0 has no scoreboard entry to clear.
  assign w_push     = lsu_rsp_valid & lsu_rsp_ready & (lsu_rsp_rd != '0);
  assign w_pop      = Men_wb;

  assign wbck_en        = r_wbck_en;
  assign wbck_dest_idx  = r_wbck_idx;
  assign wbck_dest_data = r_wbck_data;

  assign Men_wb       = ~w_empty & ~wb_hold;
  assign Mrd_wb       = r_rd_mem[r_rd_ptr];
  assign Mdata_wb     = r_data_mem[r_rd_ptr];
  assign load_pending = ~w_empty;
  assign load_err     = Men_wb & r_err_mem[r_rd_ptr];

`ifdef WBCK_LOAD_EXT_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = lsu_rsp_data[{lsu_rsp_addr_lo, 3'b000} +: 8];
  assign w_half = lsu_rsp_data[{lsu_rsp_addr_lo[1], 4'b0000} +: 16];
`else
  logic w_unused_ext;

  assign w_unused_ext = ^{lsu_rsp_funct3, lsu_rsp_addr_lo};
`endif

  always_comb begin
    w_ext_data = lsu_rsp_data;
    w_ext_err  = lsu_rsp_err;
`ifdef WBCK_LOAD_EXT_EN
    case (lsu_rsp_funct3)
      3'b000:  w_ext_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ext_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b010:  w_ext_data = lsu_rsp_data;
      3'b100:  w_ext_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ext_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext_err  = 1'b1;
    endcase
`endif
    // Bus errors still write rd (with zero) so the scoreboard entry is released.
    if (lsu_rsp_err) begin
      w_ext_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbck_en   <= 1'b0;
      r_wbck_idx  <= '0;
      r_wbck_data <= '0;
    end else begin
      r_wbck_en <= w_ex_write;
      if (w_ex_write) begin
        r_wbck_idx  <= ex_rd;
        r_wbck_data <= ex_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]   <= lsu_rsp_rd;
      r_data_mem[r_wr_ptr] <= w_ext_data;
      r_err_mem[r_wr_ptr]  <= w_ext_err;
    end
  end

endmodule

// File: tb/tb_wbck_unit.sv
// tb/tb_wbck_unit.sv - scoreboard bench for wbck_unit with a queue-based reference model
module tb_wbck_unit;
  localparam int XLEN     = 32;
  localparam int IDX_W    = 5;
  localparam int LQ_DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_regwrite;
  logic [IDX_W-1:0] ex_rd;
  logic [XLEN-1:0]  ex_data;
  logic             lsu_rsp_valid;
  logic             lsu_rsp_ready;
  logic [IDX_W-1:0] lsu_rsp_rd;
  logic [XLEN-1:0]  lsu_rsp_data;
  logic [2:0]       lsu_rsp_funct3;
  logic [1:0]       lsu_rsp_addr_lo;
  logic             lsu_rsp_err;
  logic             wb_hold;
  logic             wbck_en;
  logic [IDX_W-1:0] wbck_dest_idx;
  logic [XLEN-1:0]  wbck_dest_data;
  logic             Men_wb;
  logic [IDX_W-1:0] Mrd_wb;
  logic [XLEN-1:0]  Mdata_wb;
  logic             load_pending;
  logic             load_err;

  always #5 clk = ~clk;

  wbck_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rd(lsu_rsp_rd), .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_funct3(lsu_rsp_funct3), .lsu_rsp_addr_lo(lsu_rsp_addr_lo),
    .lsu_rsp_err(lsu_rsp_err), .wb_hold(wb_hold),
    .wbck_en(wbck_en), .wbck_dest_idx(wbck_dest_idx), .wbck_dest_data(wbck_dest_data),
    .Men_wb(Men_wb), .Mrd_wb(Mrd_wb), .Mdata_wb(Mdata_wb),
    .load_pending(load_pending), .load_err(load_err)
  );

  typedef struct {
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  data;
    bit               err;
    int               due;
  } wr_t;

  wr_t ex_q[$];
  wr_t ld_q[$];
  wr_t fifo[$];
  wr_t m_ex;
  wr_t m_ld;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic wr_t ref_load(input logic [IDX_W-1:0] rd, input logic [31:0] d,
                                   input logic [2:0] f3, input logic [1:0] al, input bit e);
    wr_t w;
    int unsigned b;
    int unsigned h;
    w.rd   = rd;
    w.data = d;
    w.err  = e;
    w.due  = 0;
    b = (d >> (8 * al)) & 32'hFF;
    h = (d >> (16 * al[1])) & 32'hFFFF;
`ifdef WBCK_LOAD_EXT_EN
    case (f3)
      3'd0: w.data = (b >= 128) ? b - 256 : b;
      3'd1: w.data = (h >= 32768) ? h - 65536 : h;
      3'd2: w.data = d;
      3'd4: w.data = b;
      3'd5: w.data = h;
      default: w.err = 1'b1;
    endcase
`else
    if (b == 32'hFFFF_FFFF && h == 32'hFFFF_FFFF && f3 == 3'd7) w.data = d;
`endif
    if (e) w.data = '0;
    return w;
  endfunction

  // One clock cycle: drive inputs, check handshakes, advance the reference model at the edge.
  task automatic step(input bit r, input bit hold,
                      input bit exv, input bit exw, input logic [4:0] exrd, input logic [31:0] exd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] al, input bit le);
    wr_t w;
    bit  rdy;
    rst = r; wb_hold = hold;
    ex_valid = exv; ex_regwrite = exw; ex_rd = exrd; ex_data = exd;
    lsu_rsp_valid = lv; lsu_rsp_rd = lrd; lsu_rsp_data = ld;
    lsu_rsp_funct3 = f3; lsu_rsp_addr_lo = al; lsu_rsp_err = le;
    #1;
    chk("ex_ready", ex_ready, 32'(!r && !hold));
    rdy = !r && (fifo.size() < LQ_DEPTH);
    chk("lsu_rsp_ready", lsu_rsp_ready, 32'(rdy));
    if (!r) chk("load_pending", load_pending, 32'(fifo.size() > 0));
    if (fifo.size() > 0 && !hold) begin
      w = fifo.pop_front();
      w.due = cyc;
      ld_q.push_back(w);
    end
    if (lv && rdy && lrd != 0) fifo.push_back(ref_load(lrd, ld, f3, al, le));
    if (!r && !hold && exv && exw && exrd != 0) begin
      w.rd = exrd; w.data = exd; w.err = 1'b0; w.due = cyc + 1;
      ex_q.push_back(w);
    end
    if (r) fifo.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit hold);
    step(1'b0, hold, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wbck_en === 1'b1) begin
        if (ex_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ex_unexpected: wbck_en=1 idx=%0d data=%h, required no write", wbck_dest_idx, wbck_dest_data);
        end else begin
          m_ex = ex_q.pop_front();
          chk("ex_idx", 32'(wbck_dest_idx), 32'(m_ex.rd));
          chk("ex_data", wbck_dest_data, m_ex.data);
          chk("ex_cycle", cyc, m_ex.due);
        end
      end else if (ex_q.size() > 0 && ex_q[0].due <= cyc) begin
        chk("ex_missing", 32'(wbck_en), 32'd1);
        void'(ex_q.pop_front());
      end
      if (Men_wb === 1'b1) begin
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ld_unexpected: Men_wb=1 rd=%0d data=%h, required no write", Mrd_wb, Mdata_wb);
        end else begin
          m_ld = ld_q.pop_front();
          chk("ld_rd", 32'(Mrd_wb), 32'(m_ld.rd));
          chk("ld_data", Mdata_wb, m_ld.data);
          chk("ld_err", 32'(load_err), 32'(m_ld.err));
          chk("ld_cycle", cyc, m_ld.due);
        end
      end else begin
        chk("load_err_idle", 32'(load_err), 32'd0);
        if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
          chk("ld_missing", 32'(Men_wb), 32'd1);
          void'(ld_q.pop_front());
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    chk("rst_wbck_en", 32'(wbck_en), 32'd0);
    chk("rst_wbck_idx", 32'(wbck_dest_idx), 32'd0);
    chk("rst_wbck_data", wbck_dest_data, 32'd0);
    chk("rst_men_wb", 32'(Men_wb), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    mon_en = 1'b1;

    // EX write, then non-writing EX results.
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h2222_2222, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    idle(1'b0);

    // Sub-word loads (raw words when extraction is disabled).
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0080_0000, 3'b000, 2'd2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8001_0000, 3'b101, 2'd2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234_5678, 3'b011, 2'd0, 1'b0);
    idle(1'b0);

    // Fill under hold, then drain rd 1,2,3 on consecutive cycles.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'hA1, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hA2, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA3, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA3, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA3, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA3, 3'b010, 2'd0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Bus-error load, rd==0 discard, and EX result surviving a following hold.
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_F00D, 3'b010, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA, 1'b1, 5'd0, 32'hBAD0_BAD0, 3'b010, 2'd0, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Reset with queued loads and a registered EX result.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h10, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h11, 3'b010, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h1212_1212, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0);
    chk("post_rst_pending", 32'(load_pending), 32'd0);
    chk("post_rst_wbck_en", 32'(wbck_en), 32'd0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h6666_0001, 1'b1, 5'd13, 32'h8000_00FF, 3'b000, 2'd0, 1'b0);
    idle(1'b0);

    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), 32'($urandom),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 5; i++) idle(1'b0);

    chk("ex_q_drained", 32'(ex_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    chk("fifo_drained", 32'(load_pending), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
